prediction_table_update_scheduler: RTL and testbench

Owns the single write port of a branch prediction table. It serialises two update streams onto that port: rollback updates from the pipeline and corrected-outcome updates from branch resolution. After reset it sequences table initialisation. It also forwards not-yet-written counter values to the lookup path, so reads never see stale counts.

---
 rtl/prediction_table_update_scheduler_if.sv | 36 +++
 rtl/prediction_table_update_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_prediction_table_update_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prediction_table_update_scheduler_if.sv
// Bundles the update, lookup and table-write signals of the prediction table update scheduler.
// The scheduler uses the slave modport; the producer/consumer side uses master.
interface prediction_table_update_scheduler_if #(
    parameter int unsigned INDEX_WIDTH   = 8,
    parameter int unsigned COUNTER_WIDTH = 2
);
    logic                     rb_valid;
    logic [INDEX_WIDTH-1:0]   rb_index;
    logic [COUNTER_WIDTH-1:0] rb_count;
    logic                     cr_valid;
    logic [INDEX_WIDTH-1:0]   cr_index;
    logic [COUNTER_WIDTH-1:0] cr_count;
    logic                     cr_ready;
    logic                     flush;
    logic [INDEX_WIDTH-1:0]   lookup_index;
    logic                     lookup_hit;
    logic [COUNTER_WIDTH-1:0] lookup_count;
    logic                     init_busy;
    logic                     wr_en;
    logic [INDEX_WIDTH-1:0]   wr_index;
    logic [COUNTER_WIDTH-1:0] wr_count;
    logic [15:0]              stat_stall_cnt;
    logic [15:0]              stat_kill_cnt;

    modport master (
        output rb_valid, rb_index, rb_count, cr_valid, cr_index, cr_count, flush, lookup_index,
        input  cr_ready, lookup_hit, lookup_count, init_busy, wr_en, wr_index, wr_count,
               stat_stall_cnt, stat_kill_cnt
    );

    modport slave (
        input  rb_valid, rb_index, rb_count, cr_valid, cr_index, cr_count, flush, lookup_index,
        output cr_ready, lookup_hit, lookup_count, init_busy, wr_en, wr_index, wr_count,
               stat_stall_cnt, stat_kill_cnt
    );
endinterface

// File: rtl/prediction_table_update_scheduler.sv
// Owns the prediction table write port: init sweep, rollback/corrected update arbitration with a
// kill-capable corrected queue, and lookup forwarding. `PRED_SCHED_STATS_EN adds stall/kill stats.
module prediction_table_update_scheduler #(
    parameter int unsigned INDEX_WIDTH        = 8,
    parameter int unsigned COUNTER_WIDTH      = 2,
    parameter int unsigned COUNTER_INIT_VALUE = 0,
    parameter int unsigned QUEUE_DEPTH        = 4
) (
    input logic clk,
    input logic rst_n,
    prediction_table_update_scheduler_if.slave bus
);
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [COUNTER_WIDTH-1:0] InitCount = COUNTER_WIDTH'(COUNTER_INIT_VALUE);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   init_ptr_q, init_ptr_d;
    logic                     wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0]   wr_index_q, wr_index_d;
    logic [COUNTER_WIDTH-1:0] wr_count_q, wr_count_d;

    logic [INDEX_WIDTH-1:0]   q_index_q [QUEUE_DEPTH];
    logic [INDEX_WIDTH-1:0]   q_index_d [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] q_count_q [QUEUE_DEPTH];
    logic [COUNTER_WIDTH-1:0] q_count_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]   q_valid_q, q_valid_d;
    logic [PtrW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]          fill_q, fill_d;

    logic [QUEUE_DEPTH-1:0]   occupied;
    logic [QUEUE_DEPTH-1:0]   rb_match;
    logic [CntW-1:0]          skip;
    logic [CntW-1:0]          live_fill;
    logic [PtrW-1:0]          live_head;
    logic                     cr_ready;
    logic                     fwd_hit;
    logic [COUNTER_WIDTH-1:0] fwd_count;

    // Killed entries keep their slot until they reach the head; skip counts the leading ones.
    always_comb begin : queue_scan
        logic            found;
        logic [PtrW-1:0] slot;
        occupied = '0;
        rb_match = '0;
        skip     = '0;
        found    = 1'b0;
        slot     = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            slot = head_q + PtrW'(i);
            if (CntW'(i) < fill_q) begin
                occupied[slot] = 1'b1;
                if (q_valid_q[slot]) begin
                    found = 1'b1;
                end else if (!found) begin
                    skip = skip + CntW'(1);
                end
            end
        end
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            rb_match[i] = occupied[i] & q_valid_q[i] & (q_index_q[i] == bus.rb_index);
        end
    end

    assign live_fill = fill_q - skip;
    assign live_head = head_q + skip[PtrW-1:0];
    assign cr_ready  = (state_q == StRun) && (fill_q != CntW'(QUEUE_DEPTH)) && !bus.flush;

    always_comb begin : next_state
        logic            bypass;
        logic            push;
        logic [CntW-1:0] pop_n;
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_count_d = wr_count_q;
        q_index_d  = q_index_q;
        q_count_d  = q_count_q;
        q_valid_d  = q_valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        bypass     = 1'b0;
        push       = 1'b0;
        pop_n      = '0;
        unique case (state_q)
            StInit: begin
                wr_en_d    = 1'b1;
                wr_index_d = init_ptr_q;
                wr_count_d = InitCount;
                init_ptr_d = init_ptr_q + INDEX_WIDTH'(1);
                if (init_ptr_q == {INDEX_WIDTH{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.rb_valid) begin
                    wr_en_d    = 1'b1;
                    wr_index_d = bus.rb_index;
                    wr_count_d = bus.rb_count;
                    pop_n      = skip;
                    q_valid_d  = q_valid_q & ~rb_match;
                end else if (bus.flush) begin
                    pop_n = '0;
                end else if (live_fill != '0) begin
                    wr_en_d    = 1'b1;
                    wr_index_d = q_index_q[live_head];
                    wr_count_d = q_count_q[live_head];
                    pop_n      = skip + CntW'(1);
                end else begin
                    pop_n = skip;
                    if (bus.cr_valid && cr_ready) begin
                        bypass     = 1'b1;
                        wr_en_d    = 1'b1;
                        wr_index_d = bus.cr_index;
                        wr_count_d = bus.cr_count;
                    end
                end
                push = bus.cr_valid && cr_ready && !bypass;
                if (push) begin
                    q_index_d[tail_q] = bus.cr_index;
                    q_count_d[tail_q] = bus.cr_count;
                    q_valid_d[tail_q] = 1'b1;
                end
                head_d = head_q + pop_n[PtrW-1:0];
                tail_d = tail_q + PtrW'(push);
                fill_d = fill_q - pop_n + CntW'(push);
                if (bus.flush) begin
                    head_d    = '0;
                    tail_d    = '0;
                    fill_d    = '0;
                    q_valid_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_ptr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_count_q <= '0;
            q_valid_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_count_q <= wr_count_d;
            q_valid_q  <= q_valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
        end
    end

    // Payload needs no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        q_index_q <= q_index_d;
        q_count_q <= q_count_d;
    end

    // Scan oldest to newest so the newest matching queued entry overrides the write register.
    always_comb begin : forward
        logic [PtrW-1:0] slot;
        fwd_hit   = 1'b0;
        fwd_count = '0;
        slot      = '0;
        if (!rst_n) begin
            fwd_hit = 1'b0;
        end else if (state_q == StInit) begin
            fwd_hit   = 1'b1;
            fwd_count = InitCount;
        end else begin
            if (wr_en_q && (wr_index_q == bus.lookup_index)) begin
                fwd_hit   = 1'b1;
                fwd_count = wr_count_q;
            end
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot = head_q + PtrW'(i);
                if (occupied[slot] && q_valid_q[slot] && (q_index_q[slot] == bus.lookup_index)) begin
                    fwd_hit   = 1'b1;
                    fwd_count = q_count_q[slot];
                end
            end
        end
    end

    assign bus.cr_ready     = cr_ready;
    assign bus.lookup_hit   = fwd_hit;
    assign bus.lookup_count = fwd_count;
    assign bus.init_busy    = (state_q == StInit);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_index     = wr_index_q;
    assign bus.wr_count     = wr_count_q;

`ifdef PRED_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if ((state_q == StRun) && bus.cr_valid && !cr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if ((state_q == StRun) && bus.rb_valid && (|rb_match) && (kill_cnt_q != 16'hFFFF)) begin
            kill_cnt_d = kill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign bus.stat_stall_cnt = stall_cnt_q;
    assign bus.stat_kill_cnt  = kill_cnt_q;
`else
    assign bus.stat_stall_cnt = '0;
    assign bus.stat_kill_cnt  = '0;
`endif
endmodule

// File: tb/tb_prediction_table_update_scheduler.sv
// Randomised and directed bench for prediction_table_update_scheduler against a queue-level
// reference model; every output is compared each cycle.
module tb_prediction_table_update_scheduler;
    localparam int unsigned IW       = 4;
    localparam int unsigned CW       = 2;
    localparam int unsigned INIT_VAL = 0;
    localparam int unsigned QD       = 4;
    localparam int unsigned NENT     = 1 << IW;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          valid;
    } entry_t;

    bit clk;
    bit rst_n;
    int n_checks;
    int n_pass;

    entry_t mq[$];
    bit     m_known;
    bit     m_run;
    int     m_ptr;
    bit     m_wr_en;
    int     m_wr_idx;
    int     m_wr_cnt;
    int     m_stall;
    int     m_kill;
    bit     junk;

    prediction_table_update_scheduler_if #(.INDEX_WIDTH(IW), .COUNTER_WIDTH(CW)) bus_if ();

    prediction_table_update_scheduler #(
        .INDEX_WIDTH       (IW),
        .COUNTER_WIDTH     (CW),
        .COUNTER_INIT_VALUE(INIT_VAL),
        .QUEUE_DEPTH       (QD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input bit rbv, input int rbi, input int rbc,
                         input bit crv, input int cri, input int crc, input bit fl);
        bus_if.rb_valid = rbv;
        bus_if.rb_index = IW'(rbi);
        bus_if.rb_count = CW'(rbc);
        bus_if.cr_valid = crv;
        bus_if.cr_index = IW'(cri);
        bus_if.cr_count = CW'(crc);
        bus_if.flush    = fl;
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_ptr    = 0;
        m_wr_en  = 0;
        m_wr_idx = 0;
        m_wr_cnt = 0;
        m_stall  = 0;
        m_kill   = 0;
        mq.delete();
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model.
    task automatic step(output bit acc);
        bit     ready;
        bit     hit;
        int     fcnt;
        bit     bypass;
        bit     killed;
        entry_t e;
        @(negedge clk);
        ready = m_run && (mq.size() < QD) && !bus_if.flush;
        acc   = rst_n && bus_if.cr_valid && ready;
        hit   = 0;
        fcnt  = 0;
        if (rst_n) begin
            if (!m_run) begin
                hit  = 1;
                fcnt = INIT_VAL;
            end else begin
                if (m_wr_en && m_wr_idx == int'(bus_if.lookup_index)) begin
                    hit  = 1;
                    fcnt = m_wr_cnt;
                end
                foreach (mq[i]) begin
                    if (mq[i].valid && mq[i].idx == bus_if.lookup_index) begin
                        hit  = 1;
                        fcnt = int'(mq[i].cnt);
                    end
                end
            end
        end
        if (m_known) begin
            check_eq("init_busy", 32'(bus_if.init_busy), 32'(!m_run));
            check_eq("cr_ready", 32'(bus_if.cr_ready), 32'(ready));
            check_eq("wr_en", 32'(bus_if.wr_en), 32'(m_wr_en));
            check_eq("wr_index", 32'(bus_if.wr_index), 32'(m_wr_idx));
            check_eq("wr_count", 32'(bus_if.wr_count), 32'(m_wr_cnt));
            check_eq("lookup_hit", 32'(bus_if.lookup_hit), 32'(hit));
            check_eq("lookup_count", 32'(bus_if.lookup_count), 32'(fcnt));
`ifdef PRED_SCHED_STATS_EN
            check_eq("stat_stall", 32'(bus_if.stat_stall_cnt), 32'(m_stall));
            check_eq("stat_kill", 32'(bus_if.stat_kill_cnt), 32'(m_kill));
`else
            check_eq("stat_stall", 32'(bus_if.stat_stall_cnt), 32'd0);
            check_eq("stat_kill", 32'(bus_if.stat_kill_cnt), 32'd0);
`endif
        end
        if (!rst_n) begin
            model_reset();
            m_known = 1;
        end else if (!m_run) begin
            m_wr_en  = 1;
            m_wr_idx = m_ptr;
            m_wr_cnt = INIT_VAL;
            if (m_ptr == NENT - 1) m_run = 1;
            m_ptr = (m_ptr + 1) % NENT;
        end else begin
            if (bus_if.cr_valid && !ready && m_stall < 65535) m_stall++;
            while (mq.size() > 0 && !mq[0].valid) void'(mq.pop_front());
            bypass = 0;
            if (bus_if.rb_valid) begin
                m_wr_en  = 1;
                m_wr_idx = int'(bus_if.rb_index);
                m_wr_cnt = int'(bus_if.rb_count);
                killed   = 0;
                foreach (mq[i]) begin
                    if (mq[i].valid && mq[i].idx == bus_if.rb_index) begin
                        e       = mq[i];
                        e.valid = 0;
                        mq[i]   = e;
                        killed  = 1;
                    end
                end
                if (killed && m_kill < 65535) m_kill++;
            end else if (bus_if.flush) begin
                m_wr_en = 0;
            end else if (mq.size() > 0) begin
                e        = mq.pop_front();
                m_wr_en  = 1;
                m_wr_idx = int'(e.idx);
                m_wr_cnt = int'(e.cnt);
            end else if (bus_if.cr_valid && ready) begin
                bypass   = 1;
                m_wr_en  = 1;
                m_wr_idx = int'(bus_if.cr_index);
                m_wr_cnt = int'(bus_if.cr_count);
            end else begin
                m_wr_en = 0;
            end
            if (bus_if.cr_valid && ready && !bypass) begin
                e.idx   = bus_if.cr_index;
                e.cnt   = bus_if.cr_count;
                e.valid = 1;
                mq.push_back(e);
            end
            if (bus_if.flush) mq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) step(junk);
    endtask

    initial begin
        bit acc;
        int k;
        n_checks = 0;
        n_pass   = 0;
        m_known  = 0;
        rst_n    = 0;
        bus_if.lookup_index = '0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(junk);
        rst_n = 1;

        // Init sweep with requests present: they must be ignored.
        drive(1, 2, 1, 1, 4, 3, 1);
        repeat (NENT) step(junk);
        check_eq("init_done_busy", 32'(bus_if.init_busy), 32'd0);
        check_eq("init_last_index", 32'(bus_if.wr_index), 32'(NENT - 1));
        idle(1);
        check_eq("run_idle_wr_en", 32'(bus_if.wr_en), 32'd0);

        // Bypass of a lone corrected update.
        drive(0, 0, 0, 1, 3, 2, 0);
        step(junk);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_eq("bypass_index", 32'(bus_if.wr_index), 32'd3);
        check_eq("bypass_count", 32'(bus_if.wr_count), 32'd2);
        idle(1);

        // Rollback and corrected together.
        drive(1, 5, 1, 1, 6, 3, 0);
        bus_if.lookup_index = IW'(6);
        step(junk);
        idle(3);

        // Hold rollback for 4 cycles against 5 corrected requests.
        k = 0;
        for (int c = 0; c < 12; c++) begin
            drive(c < 4, 1, 2, k < 5, 8 + k, k % 4, 0);
            bus_if.lookup_index = IW'(8 + (c % 5));
            step(acc);
            if (acc) k++;
        end
        idle(2);

        // Kill a queued entry.
        drive(1, 1, 1, 1, 7, 2, 0);
        bus_if.lookup_index = IW'(7);
        step(junk);
        drive(1, 7, 0, 0, 0, 0, 0);
        step(junk);
        idle(4);

        // Flush with three queued entries and a concurrent rollback.
        for (int c = 0; c < 3; c++) begin
            drive(1, 2, 3, 1, 10 + c, c, 0);
            step(junk);
        end
        drive(1, 9, 1, 1, 13, 1, 1);
        bus_if.lookup_index = IW'(11);
        step(junk);
        idle(4);

        // Reset in the middle of RUN with a populated queue.
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 1, 1, 4 + c, 2, 0);
            step(junk);
        end
        rst_n = 0;
        step(junk);
        rst_n = 1;
        idle(NENT + 2);

        // Random traffic over a small index range to provoke kills and forwarding hits.
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5), $urandom_range(0, 3),
                  $urandom_range(0, 4) < 3, $urandom_range(0, 5), $urandom_range(0, 3),
                  $urandom_range(0, 19) == 0);
            bus_if.lookup_index = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, NENT - 1))
                                                              : IW'($urandom_range(0, 5));
            rst_n = ($urandom_range(0, 599) != 0);
            step(junk);
        end
        rst_n = 1;
        idle(NENT + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
